sd_decimation_controller: RTL
=============================

Name: sd_decimation_controller

Overview:
- Sequencer for the sigma-delta receive chain: 2nd-order modulator -> sinc3 decimator -> magnitude path.
- Generates the shared clock-enable strobe `en` from the system clock.
- Holds the modulator and filter in reset while stopped, and counts OSR enables to locate decimated frames.
- Discards the sinc3 settling frames, then presents each decimated filter word on a valid/ready output with sticky overrun detection.

Parameters:
- CLK_DIV, 4, system clocks per `en` pulse (>=1).
- OSR, 16, `en` pulses per decimated frame (>=2); must match the sinc3 OSR.
- SETTLE, 3, frames discarded after start (>=0; sinc3 order).
- DATA_WIDTH, 13, filter output width (3*ceil(log2(OSR))+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- run  in  1  level; 1 = run chain, 0 = stop
- en  out  1  clock enable to modulator/filter/magnitude; one-cycle pulse
- sdRst  out  1  active-high synchronous reset to modulator/filter
- filtIn  in  DATA_WIDTH  sinc3 output word
- outData  out  DATA_WIDTH  captured decimated sample
- outValid  out  1  outData valid
- outReady  in  1  downstream accept
- overrun  out  1  sticky: a frame was dropped
- settling  out  1  high while in SETTLE state

Behaviour:
- Reset (rst_n=0 at a clk edge), registered, takes effect next cycle:
  - state=IDLE, divCnt=0, enCnt=0, frameCnt=0.
  - en=0, sdRst=1, outData=0, outValid=0, overrun=0, settling=0.
- States: IDLE, SETTLE, RUN. All outputs are registered.
- IDLE:
  - Outputs: en=0, sdRst=1, counters held at 0.
  - run=1 -> SETTLE next cycle; if SETTLE=0 -> RUN directly.
  - On leaving IDLE: overrun cleared.
- Define T0 as the first cycle in SETTLE/RUN:
  - sdRst=0 from T0.
  - divCnt counts 0..CLK_DIV-1 and wraps.
  - en=1 in cycles T0+k*CLK_DIV-1 for k>=1, i.e. one pulse every CLK_DIV cycles.
  - CLK_DIV=1: en held high continuously while active.
- Frame event:
  - enCnt counts en pulses 0..OSR-1 and wraps.
  - The en pulse that wraps enCnt makes the next cycle a capture cycle. Captures occur at T0+n*OSR*CLK_DIV, n>=1.
- SETTLE:
  - Each capture increments frameCnt; filtIn is ignored.
  - After the SETTLE-th capture -> RUN. Divider and enCnt continue without a gap.
- RUN capture:
  - If outValid=0, or outValid=1 with outReady=1 in the same cycle: outData<=filtIn, outValid<=1.
  - Else the new word is dropped, outData is unchanged, and overrun<=1 (sticky).
- Handshake:
  - outValid&outReady with no capture -> outValid<=0 next cycle.
  - outData is stable while outValid=1 and outReady=0.
- run=0 in SETTLE/RUN -> IDLE next cycle:
  - en=0 and sdRst=1 from that cycle; counters cleared.
  - outValid cleared; overrun retained until the next start.
  - A capture coinciding with the run=0 cycle is still processed.
- run toggled 1->0->1: full restart; settle frames discarded again.
- rst_n=0 mid-operation overrides everything, including a same-cycle capture.
- Latency with defaults: first outValid at T0+(SETTLE+1)*OSR*CLK_DIV+1 = T0+257.

Test Plan:
- Reset, run=1: sdRst 1->0 at T0; en pulses at T0+3, T0+7, T0+11; period 4, width 1.
- Defaults, filtIn ramps by +1 per cycle from 0, outReady=1: captures at T0+64/128/192 dropped (settling=1). outValid rises T0+257 with outData=filtIn sampled at T0+256. Next word follows 64 cycles later.
- outReady=0 through two RUN captures: first word held, second dropped, overrun=1 and stays 1. outReady=1 pulse -> outValid=0. Stop/start -> overrun=0.
- outValid=1 and outReady=1 in the capture cycle: new word loaded, outValid stays 1, no overrun.
- run=0 at T0+150: next cycle state=IDLE, en=0, sdRst=1, outValid=0. run=1 again -> fresh T0, three frames discarded again.
- CLK_DIV=1, OSR=2, SETTLE=0: IDLE->RUN directly, en constant 1, capture every 2 cycles; rst_n=0 mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sd_decimation_controller.sv
// Sequencer for the sigma-delta receive chain: shared clock-enable, modulator/filter reset,
// settling-frame discard and a valid/ready output stage with sticky overrun.
module sd_decimation_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned OSR        = 16,
  parameter int unsigned SETTLE     = 3,
  parameter int unsigned DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic                  en,
  output logic                  sdRst,
  input  logic [DATA_WIDTH-1:0] filtIn,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  overrun,
  output logic                  settling
);

  localparam int unsigned DivW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EnW        = $clog2(OSR);
  localparam int unsigned FrW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned SettleLast = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

  state_e                  state_q, state_d;
  logic [DivW-1:0]         div_q, div_d;
  logic [EnW-1:0]          en_cnt_q, en_cnt_d;
  logic [FrW-1:0]          frame_q, frame_d;
  logic                    cap_q, cap_d;
  logic                    en_q, en_d;
  logic                    sd_rst_q, sd_rst_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    settling_q, settling_d;

  logic active, go, starting;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = (SETTLE == 0) ? StRun : StSettle;
      end
      StSettle: begin
        if (!run) begin
          state_d = StIdle;
        end else if (cap_q && (frame_q == FrW'(SettleLast))) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign active   = (state_q != StIdle);
  assign go       = (state_d != StIdle);
  assign starting = !active && go;

  always_comb begin
    div_d       = '0;
    en_cnt_d    = '0;
    frame_d     = '0;
    cap_d       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !outReady;
    overrun_d   = overrun_q;

    if (active && go) begin
      div_d    = (div_q == DivW'(CLK_DIV - 1)) ? '0 : div_q + DivW'(1);
      en_cnt_d = en_cnt_q;
      if (en_q) en_cnt_d = (en_cnt_q == EnW'(OSR - 1)) ? '0 : en_cnt_q + EnW'(1);
      // The wrapping enable marks the following cycle as the frame boundary.
      cap_d    = en_q && (en_cnt_q == EnW'(OSR - 1));
      frame_d  = frame_q;
      if (state_q == StSettle && cap_q) frame_d = frame_q + FrW'(1);
    end

    en_d       = go && (div_d == DivW'(CLK_DIV - 1));
    sd_rst_d   = !go;
    settling_d = (state_d == StSettle);

    // A capture in the stop cycle still updates data/overrun; stopping still drops valid.
    if (state_q == StRun && cap_q) begin
      if (!out_valid_q || outReady) begin
        out_data_d  = filtIn;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (!go) out_valid_d = 1'b0;
    if (starting) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      en_cnt_q    <= '0;
      frame_q     <= '0;
      cap_q       <= 1'b0;
      en_q        <= 1'b0;
      sd_rst_q    <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      settling_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      en_cnt_q    <= en_cnt_d;
      frame_q     <= frame_d;
      cap_q       <= cap_d;
      en_q        <= en_d;
      sd_rst_q    <= sd_rst_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      settling_q  <= settling_d;
    end
  end

  assign en       = en_q;
  assign sdRst    = sd_rst_q;
  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign overrun  = overrun_q;
  assign settling = settling_q;

endmodule
